dt_peak_scan: RTL
=================

Name: dt_peak_scan

Overview:
- Post-processing stage directly downstream of the DT core; consumes the distance map DT leaves in res_RAM.
- Started by DT's done. Streams every result pixel out of res_RAM through the standard read port and reports:
  - maximum distance value and the first address holding it;
  - number of pixels equal to that maximum;
  - object area (count of nonzero pixels).
- Results feed the medial-axis/peak reporting logic. The block never writes res_RAM.

Parameters:
- ADDR_W, 14, res_RAM address width.
- DATA_W, 8, distance value width.
- N_PIX, 16384, pixels scanned (128x128). Must be ≥ 2 and ≤ 2^ADDR_W. Reduced values are allowed for unit test.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan (driven from DT done).
- res_rd  out  1  read enable to res_RAM.
- res_addr  out  ADDR_W  read address to res_RAM.
- res_di  in  DATA_W  res_RAM read data; valid at the posedge after the address is driven.
- busy  out  1  high while a scan is in progress.
- done  out  1  high when results are valid; held until next accepted start or reset.
- max_val  out  DATA_W  largest distance value found.
- max_addr  out  ADDR_W  lowest address holding max_val.
- max_cnt  out  ADDR_W+1  number of pixels equal to max_val.
- area  out  ADDR_W+1  number of pixels with value != 0.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state = IDLE.
  - res_rd = 0, res_addr = 0, busy = 0, done = 0.
  - max_val = 0, max_addr = 0, max_cnt = 0, area = 0.
- States: IDLE, SCAN, DONE.
- IDLE or DONE, start = 1 at edge E:
  - After E: state SCAN, busy = 1, done = 0, res_rd = 1, res_addr = 0.
  - Result registers cleared; the internal data-valid pipeline flag is cleared.
- SCAN, address issue:
  - After edge E+k, res_addr = k for k = 0..N_PIX-1.
  - res_rd stays 1 through the cycle in which addr N_PIX-1 is driven.
- Memory timing:
  - res_RAM samples the address at negedge and presents data by the next posedge.
  - Data for address k is sampled at edge E+k+1. This is a one-cycle read latency, fully pipelined at one pixel per cycle.
- SCAN, per sampled pixel value v at address a:
  - v != 0 → area += 1.
  - First pixel of the scan → max_val = v, max_addr = a, max_cnt = 1.
  - v > max_val → max_val = v, max_addr = a, max_cnt = 1.
  - v == max_val → max_cnt += 1; max_addr unchanged (first occurrence wins).
  - v < max_val → no change.
  - Comparisons are unsigned.
  - Counters are ADDR_W+1 wide and cannot overflow for N_PIX ≤ 2^ADDR_W.
- Completion:
  - At edge E+N_PIX the last pixel (address N_PIX-1) is accumulated.
  - In the same update: state DONE, res_rd = 0, busy = 0, done = 1.
  - Total latency: done rises N_PIX cycles after the start edge.
- DONE:
  - All outputs held stable; res_rd = 0.
  - A new start restarts the scan exactly as from IDLE.
- start while in SCAN: ignored; the scan continues undisturbed.
- All-zero image: max_val = 0, max_addr = 0, max_cnt = N_PIX, area = 0.
- Reset mid-scan: next cycle is IDLE with all outputs zero. Partial results are discarded; no further reads issue.
- res_addr holds its last value when res_rd = 0. Its value is don't-care for the RAM then.
- res_di is ignored outside the sampled-data cycles of SCAN.

Test Plan:
- Reset then idle 10 cycles, no start → res_rd = 0, busy = 0, done = 0, every result output = 0.
- N_PIX=16384, RAM all 0, start → res_addr counts 0..16383 with res_rd = 1; done rises exactly 16384 cycles after the start edge; max_val = 0, max_addr = 0, max_cnt = 16384, area = 0.
- RAM = 0 except [130]=1, [131]=2, [259]=2, [5000]=1, start → max_val = 2, max_addr = 131, max_cnt = 2, area = 4.
- Boundary: [0]=0x7F and [16383]=0xFF, others 0 → max_val = 0xFF, max_addr = 16383, max_cnt = 1, area = 2. Confirms the last pixel is accumulated before done.
- Reset asserted at cycle 500 of a scan, then start again on the third test's image → first scan aborted (outputs 0, res_rd = 0); second scan gives max_val = 2, max_addr = 131, max_cnt = 2, area = 4.
- N_PIX=16: start pulses during SCAN ignored (done still at exactly 16 cycles). A second start while in DONE re-clears the results and reproduces identical values.

Source files
------------

// File: rtl/dt_peak_scan.sv
// Peak scan of the DT distance map: streams res_RAM once and reports the
// maximum value, its first address, its multiplicity and the nonzero area.
module dt_peak_scan #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_PIX  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_di,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W:0]   max_cnt,
  output logic [ADDR_W:0]   area
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                first_q, first_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mv_q, mv_d;
  logic [ADDR_W-1:0]   ma_q, ma_d;
  logic [CNT_W-1:0]    mc_q, mc_d;
  logic [CNT_W-1:0]    ar_q, ar_d;

  // Next-state and accumulation. rd_q doubles as the data-valid flag:
  // the pixel on res_di belongs to the address driven in the previous cycle.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mv_d    = mv_q;
    ma_d    = ma_q;
    mc_d    = mc_q;
    ar_d    = ar_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
          rd_d    = 1'b1;
          addr_d  = '0;
          first_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          mv_d    = '0;
          ma_d    = '0;
          mc_d    = '0;
          ar_d    = '0;
        end
      end
      S_SCAN: begin
        if (rd_q) begin
          if (res_di != '0) begin
            ar_d = ar_q + CNT_W'(1);
          end
          if (first_q || (res_di > mv_q)) begin
            mv_d = res_di;
            ma_d = addr_q;
            mc_d = CNT_W'(1);
          end else if (res_di == mv_q) begin
            mc_d = mc_q + CNT_W'(1);
          end
          first_d = 1'b0;

          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            rd_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mv_q    <= '0;
      ma_q    <= '0;
      mc_q    <= '0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mv_q    <= mv_d;
      ma_q    <= ma_d;
      mc_q    <= mc_d;
      ar_q    <= ar_d;
    end
  end

  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = mv_q;
  assign max_addr = ma_q;
  assign max_cnt  = mc_q;
  assign area     = ar_q;

endmodule
